// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encoding and counter sizing used by the top and its datapath.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-divide step.
// A negative result means the divisor did not fit.
module div_trial_sub
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           neg
);

  assign diff = a - b;
  assign neg  = diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtract per clock.
// Outputs are registered and hold until the next completion.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd;
  logic             dz;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             neg;

  assign shifted = {rem, q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a   (shifted),
    .b   ({1'b0, dvs}),
    .diff(diff),
    .neg (neg)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      dvd         <= '0;
      dz          <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      QUOTIENT    <= '0;
      REMAINDER   <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            dvd   <= DIVIDEND;
            dvs   <= DIVISOR;
            dz    <= (DIVISOR == '0);
            q     <= DIVIDEND;
            rem   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // a zero divisor spends one quiet cycle here, BUSY stays low
          if (dz) begin
            state       <= FINISH;
            DONE        <= 1'b1;
            QUOTIENT    <= '1;
            REMAINDER   <= dvd;
            DIV_BY_ZERO <= 1'b1;
          end else if (cnt == LAST) begin
            state       <= FINISH;
            BUSY        <= 1'b0;
            DONE        <= 1'b1;
            QUOTIENT    <= q;
            REMAINDER   <= rem;
            DIV_BY_ZERO <= 1'b0;
          end else begin
            BUSY <= 1'b1;
            cnt  <= cnt + CW'(1);
            rem  <= neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            q    <= {q[WIDTH-2:0], ~neg};
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
